// File: rtl/data_mem_resp_pkg.sv
// rtl/data_mem_resp_pkg.sv - funct3 codes, FSM states and shared helpers for data_mem_resp
package data_mem_resp_pkg;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Store and load codes share encodings, so one check covers both directions.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    case (f3)
      F3_LH, F3_LHU: return addr_lo[0];
      F3_LW:         return addr_lo != 2'b00;
      default:       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_fmt.sv
// rtl/data_mem_fmt.sv - combinational store lane/mask builder and load extender
module data_mem_fmt
  import data_mem_resp_pkg::*;
(
  input  logic [2:0]  f3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  wr_be,
  output logic [31:0] wr_word,
  output logic [31:0] ld_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    wr_be   = 4'b0000;
    wr_word = ZERO_WORD;
    case (f3)
      F3_SB: begin
        wr_be   = 4'b0001 << addr_lo;
        wr_word = {4{wdata[7:0]}};
      end
      F3_SH: begin
        wr_be   = addr_lo[1] ? 4'b1100 : 4'b0011;
        wr_word = {2{wdata[15:0]}};
      end
      F3_SW: begin
        wr_be   = 4'b1111;
        wr_word = wdata;
      end
      default: begin
        wr_be   = 4'b0000;
        wr_word = ZERO_WORD;
      end
    endcase
  end

  always_comb begin
    byte_sel = rword[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? rword[31:16] : rword[15:0];
    case (f3)
      F3_LB:   ld_word = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   ld_word = {{16{half_sel[15]}}, half_sel};
      F3_LW:   ld_word = rword;
      F3_LBU:  ld_word = {24'h0, byte_sel};
      F3_LHU:  ld_word = {16'h0, half_sel};
      default: ld_word = ZERO_WORD;
    endcase
  end

endmodule

// File: rtl/data_mem_resp.sv
// rtl/data_mem_resp.sv - multi-cycle MEM-stage data memory responder with stall request
// Optional misaligned-access trap enabled by defining DATA_MEM_MISALIGN_EN.
module data_mem_resp
  import data_mem_resp_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  write_type,
  input  logic [31:0] mem_addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        read_valid,
  output logic        mem_busy
`ifdef DATA_MEM_MISALIGN_EN
  ,
  output logic        misaligned
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW+1:0]   addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [2:0]      f3_q, f3_d;
  logic            store_q, store_d;
  logic [31:0]     read_data_q, read_data_d;
  logic            read_valid_q, read_valid_d;

  logic [31:0]     mem_q [DEPTH];
  logic            req;
  logic            mem_we;
  logic            suppress;
  logic [AW-1:0]   idx;
  logic [31:0]     rword;
  logic [31:0]     merged;
  logic [3:0]      wr_be;
  logic [31:0]     wr_word;
  logic [31:0]     ld_word;
  logic            unused_addr_hi;

  assign unused_addr_hi = ^mem_addr[31:AW+2];

  assign req   = mem_read | mem_write;
  assign idx   = addr_q[AW+1:2];
  assign rword = mem_q[idx];

`ifdef DATA_MEM_MISALIGN_EN
  logic mis_q, mis_d;
  assign suppress   = mis_q;
  assign misaligned = mis_q;
`else
  assign suppress = 1'b0;
`endif

  data_mem_fmt u_fmt (
    .f3      (f3_q),
    .addr_lo (addr_q[1:0]),
    .wdata   (wdata_q),
    .rword   (rword),
    .wr_be   (wr_be),
    .wr_word (wr_word),
    .ld_word (ld_word)
  );

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = wr_be[i] ? wr_word[8*i +: 8] : rword[8*i +: 8];
    end
  end

  assign mem_busy   = ((state_q == ST_IDLE) & req) | (state_q == ST_WAIT);
  assign read_data  = read_data_q;
  assign read_valid = read_valid_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    f3_d         = f3_q;
    store_d      = store_q;
    read_data_d  = read_data_q;
    read_valid_d = 1'b0;
    mem_we       = 1'b0;
`ifdef DATA_MEM_MISALIGN_EN
    mis_d        = mis_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          addr_d  = mem_addr[AW+1:0];
          wdata_d = write_data;
          f3_d    = write_type;
          store_d = mem_write;
          cnt_d   = CW'(LATENCY - 1);
          state_d = ST_WAIT;
`ifdef DATA_MEM_MISALIGN_EN
          mis_d   = is_misaligned(write_type, mem_addr[1:0]);
`endif
        end
      end
      ST_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          state_d = ST_DONE;
          if (!suppress) begin
            if (store_q) begin
              mem_we = 1'b1;
            end else begin
              read_data_d  = ld_word;
              read_valid_d = 1'b1;
            end
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
`ifdef DATA_MEM_MISALIGN_EN
        mis_d   = 1'b0;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= ZERO_WORD;
      f3_q         <= 3'b000;
      store_q      <= 1'b0;
      read_data_q  <= ZERO_WORD;
      read_valid_q <= 1'b0;
`ifdef DATA_MEM_MISALIGN_EN
      mis_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      f3_q         <= f3_d;
      store_q      <= store_d;
      read_data_q  <= read_data_d;
      read_valid_q <= read_valid_d;
`ifdef DATA_MEM_MISALIGN_EN
      mis_q        <= mis_d;
`endif
    end
  end

  // Gating with rst_n drops a store whose final wait edge coincides with reset.
  always_ff @(posedge clk) begin
    if (mem_we && rst_n) begin
      mem_q[idx] <= merged;
    end
  end

endmodule

// File: tb/tb_data_mem_resp.sv
// tb/tb_data_mem_resp.sv - scoreboard bench for data_mem_resp (DATA_MEM_MISALIGN_EN aware)
module tb_data_mem_resp;

  localparam logic [2:0] SB = 3'b000, SH = 3'b001, SW = 3'b010;
  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;

  logic        clk;
  logic        rst_n;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  write_type;
  logic [31:0] mem_addr;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        read_valid;
  logic        mem_busy;
`ifdef DATA_MEM_MISALIGN_EN
  logic        misaligned;
`endif

  int checks = 0;
  int passes = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];

  data_mem_resp #(.DEPTH(1024), .LATENCY(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .write_type (write_type),
    .mem_addr   (mem_addr),
    .write_data (write_data),
    .read_data  (read_data),
    .read_valid (read_valid),
    .mem_busy   (mem_busy)
`ifdef DATA_MEM_MISALIGN_EN
    ,
    .misaligned (misaligned)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n && read_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_read_valid: got read_data %h expected no pulse", read_data);
      end else begin
        check(name_q.pop_front(), read_data, exp_q.pop_front());
      end
    end
  end

  // Called #1 after a rising edge; returns #1 after the edge that ends DONE.
  task automatic access(input bit rd, input bit wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] data,
                        input logic [31:0] exp, input bit exp_rd, input bit exp_mis,
                        input string name);
    int busy;
    bit done;
    mem_read   = rd;
    mem_write  = wr;
    write_type = f3;
    mem_addr   = addr;
    write_data = data;
    if (exp_rd) begin
      exp_q.push_back(exp);
      name_q.push_back(name);
    end
    busy = 0;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (mem_busy) begin
        busy++;
        @(posedge clk);
        #1;
      end else begin
        done = 1'b1;
      end
    end
    check({name, "_busy_cycles"}, busy, 3);
`ifdef DATA_MEM_MISALIGN_EN
    check({name, "_misaligned"}, {31'b0, misaligned}, {31'b0, exp_mis});
`endif
    @(posedge clk);
    #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  initial begin
    logic [31:0] w10;
    rst_n      = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    write_type = 3'b000;
    mem_addr   = 32'h0;
    write_data = 32'h0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_read_data", read_data, 32'h0);
    check("reset_read_valid", {31'b0, read_valid}, 32'h0);
    check("reset_mem_busy", {31'b0, mem_busy}, 32'h0);
    @(posedge clk);
    #1;

    access(0, 1, SW, 32'h10, 32'hDEADBEEF, 0, 0, 0, "sw_10");
    access(1, 0, LW, 32'h10, 0, 32'hDEADBEEF, 1, 0, "lw_10");

    access(0, 1, SW,  32'h10, 32'h0, 0, 0, 0, "sw_10_clear");
    access(0, 1, SB,  32'h13, 32'hABCDEF80, 0, 0, 0, "sb_13");
    access(1, 0, LW,  32'h10, 0, 32'h80000000, 1, 0, "lw_after_sb");
    access(1, 0, LB,  32'h13, 0, 32'hFFFFFF80, 1, 0, "lb_13");
    access(1, 0, LBU, 32'h13, 0, 32'h00000080, 1, 0, "lbu_13");
    access(0, 1, SH,  32'h12, 32'h55551234, 0, 0, 0, "sh_12");
    access(1, 0, LH,  32'h12, 0, 32'h00001234, 1, 0, "lh_12");
    access(1, 0, LW,  32'h10, 0, 32'h12340000, 1, 0, "lw_after_sh");
    access(0, 1, SH,  32'h10, 32'h00008001, 0, 0, 0, "sh_10");
    check("read_data_hold_after_store", read_data, 32'h12340000);
    access(1, 0, LH,  32'h10, 0, 32'hFFFF8001, 1, 0, "lh_10");
    access(1, 0, LHU, 32'h10, 0, 32'h00008001, 1, 0, "lhu_10");
    access(1, 0, LB,  32'h11, 0, 32'hFFFFFF80, 1, 0, "lb_11");
    access(1, 0, LBU, 32'h10, 0, 32'h00000001, 1, 0, "lbu_10");
    w10 = 32'h12348001;

`ifndef DATA_MEM_MISALIGN_EN
    access(1, 0, LW, 32'h13, 0, 32'h12348001, 1, 0, "lw_13_trunc");
    access(1, 0, LH, 32'h11, 0, 32'hFFFF8001, 1, 0, "lh_11_trunc");
    access(0, 1, SW, 32'h12, 32'hA5A5A5A5, 0, 0, 0, "sw_12_trunc");
    access(1, 0, LW, 32'h10, 0, 32'hA5A5A5A5, 1, 0, "lw_after_sw_trunc");
    w10 = 32'hA5A5A5A5;
`endif

    access(1, 0, 3'b011, 32'h10, 0, 32'h0, 1, 0, "load_undef_f3");
    access(0, 1, 3'b011, 32'h10, 32'hFFFFFFFF, 0, 0, 0, "store_undef_f3");
    access(1, 0, LW, 32'h10, 0, w10, 1, 0, "lw_after_undef_store");

    access(0, 1, SW, 32'h40, 32'h600DF00D, 0, 0, 0, "b2b_sw");
    access(1, 0, LW, 32'h40, 0, 32'h600DF00D, 1, 0, "b2b_lw");
    repeat (5) @(negedge clk);
    check("idle_mem_busy", {31'b0, mem_busy}, 32'h0);
    @(posedge clk);
    #1;

    access(0, 1, SW, 32'h20, 32'h11111111, 0, 0, 0, "sw_20_pre");
    access(1, 0, LW, 32'h20, 0, 32'h11111111, 1, 0, "lw_20_pre");
    mem_write  = 1'b1;
    write_type = SW;
    mem_addr   = 32'h20;
    write_data = 32'h55;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n     = 1'b0;
    mem_write = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("midop_reset_mem_busy", {31'b0, mem_busy}, 32'h0);
    check("midop_reset_read_data", read_data, 32'h0);
    check("midop_reset_read_valid", {31'b0, read_valid}, 32'h0);
    @(posedge clk);
    #1;
    access(1, 0, LW, 32'h20, 0, 32'h11111111, 1, 0, "lw_20_post_reset");

    access(0, 1, SW, 32'h1004, 32'h7, 0, 0, 0, "sw_wrap");
    access(1, 0, LW, 32'h4, 0, 32'h7, 1, 0, "lw_wrap");

    access(1, 1, SW, 32'h30, 32'hCAFEF00D, 0, 0, 0, "rd_wr_both");
    access(1, 0, LW, 32'h30, 0, 32'hCAFEF00D, 1, 0, "lw_30");

`ifdef DATA_MEM_MISALIGN_EN
    access(1, 0, LW, 32'h11, 0, 0, 0, 1, "lw_11_mis");
    check("mis_read_data_unchanged", read_data, 32'hCAFEF00D);
    access(0, 1, SH, 32'h13, 32'hFFFF, 0, 0, 1, "sh_13_mis");
    access(1, 0, LW, 32'h10, 0, w10, 1, 0, "lw_after_mis_sh");
`endif

    repeat (4) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'h0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
